sb_ccff_loader: RTL and testbench

- Programming-side controller that loads configuration bits into the configuration-flip-flop (ccff) scan chain of a routing switch-block column (sb_* instances).
- Before loading, it checks the physical chain length with a flush-and-probe sequence.
- It then serialises WORD_W-bit configuration words from an upstream valid/ready source onto ccff_head, LSB first.
- Sits between the bitstream fetch logic and the head/tail of one switch-block configuration chain.

---
 rtl/sb_cfg_pkg.sv | 22 ++
 rtl/sb_ccff_serializer.sv | 51 +++++
 rtl/sb_ccff_loader.sv | 158 +++++++++++++++
 tb/tb_sb_ccff_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared types and sizing helpers for the switch-block configuration loader.
package sb_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_PROBE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sb_ccff_serializer.sv
// Parallel-in serial-out stage that feeds configuration words onto ccff_head, LSB first.
// A new word is taken while the last bit of the previous one shifts, so back-to-back words leave no bubble.
module sb_ccff_serializer
    import sb_cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_shift,
    output logic              o_head
);

    localparam int WB_W = cnt_width(WORD_W);
    localparam int WT_W = cnt_width(NUM_WORDS);

    logic [WORD_W-1:0] r_sreg;
    logic [WB_W-1:0]   r_wbits;
    logic [WT_W-1:0]   r_words_taken;
    logic              w_accept;

    assign o_ready  = i_en && (r_wbits <= WB_W'(1)) && (r_words_taken < WT_W'(NUM_WORDS));
    assign w_accept = o_ready && i_valid;
    assign o_shift  = i_en && (r_wbits != '0);
    assign o_head   = o_shift && r_sreg[0];

    // Leaving the load phase discards any partial word and the word tally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sreg        <= '0;
            r_wbits       <= '0;
            r_words_taken <= '0;
        end else if (!i_en) begin
            r_wbits       <= '0;
            r_words_taken <= '0;
        end else if (w_accept) begin
            r_sreg        <= i_data;
            r_wbits       <= WB_W'(WORD_W);
            r_words_taken <= r_words_taken + WT_W'(1);
        end else if (o_shift) begin
            r_sreg  <= r_sreg >> 1;
            r_wbits <= r_wbits - WB_W'(1);
        end
    end

endmodule

// File: rtl/sb_ccff_loader.sv
// Loads one switch-block ccff chain: flush, probe the physical length, then shift in NUM_WORDS words.
// Error status is sticky until the next accepted start.
module sb_ccff_loader
    import sb_cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int BC_W      = cnt_width(CHAIN_LEN - 1);
    localparam int PC_W      = cnt_width(2 * CHAIN_LEN);
    localparam int TB_W      = cnt_width(CHAIN_LEN);

    if (CHAIN_LEN <= 0 || WORD_W <= 0 || (CHAIN_LEN % WORD_W) != 0) begin : g_bad_len
        $error("sb_ccff_loader: CHAIN_LEN must be a nonzero multiple of WORD_W");
    end

    state_t          r_state;
    state_t          w_next;
    logic [BC_W-1:0] r_bit_cnt;
    logic [PC_W-1:0] r_probe_cnt;
    logic [TB_W-1:0] r_total_bits;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic            w_ser_en;
    logic            w_ser_shift;
    logic            w_ser_head;
    logic            w_set_err;
    logic [1:0]      w_err_val;

    sb_ccff_serializer #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_serializer (
        .i_clk   (prog_clk),
        .i_rst   (pReset),
        .i_en    (w_ser_en),
        .i_data  (cfg_data),
        .i_valid (cfg_valid),
        .o_ready (cfg_ready),
        .o_shift (w_ser_shift),
        .o_head  (w_ser_head)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A single 1 is injected at the head; it must reach the tail after exactly CHAIN_LEN shifts.
    always_comb begin
        w_next    = r_state;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        w_ser_en  = 1'b0;
        w_set_err = 1'b0;
        w_err_val = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                shift_en = 1'b1;
                if (r_bit_cnt == BC_W'(CHAIN_LEN - 1)) begin
                    w_next = S_PROBE;
                end
            end
            S_PROBE: begin
                shift_en  = 1'b1;
                ccff_head = (r_probe_cnt == '0);
                if (ccff_tail) begin
                    if (r_probe_cnt == PC_W'(CHAIN_LEN)) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next    = S_ERR;
                        w_set_err = 1'b1;
                        w_err_val = ERR_LEN;
                    end
                end else if (r_probe_cnt == PC_W'(2 * CHAIN_LEN)) begin
                    w_next    = S_ERR;
                    w_set_err = 1'b1;
                    w_err_val = ERR_TIMEOUT;
                end
            end
            S_LOAD: begin
                w_ser_en  = 1'b1;
                shift_en  = w_ser_shift;
                ccff_head = w_ser_head;
                if (w_ser_shift && r_total_bits == TB_W'(CHAIN_LEN - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_bit_cnt    <= '0;
            r_probe_cnt  <= '0;
            r_total_bits <= '0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_bit_cnt   <= (r_state == S_FLUSH && w_next == S_FLUSH) ? r_bit_cnt + BC_W'(1) : '0;
            r_probe_cnt <= (r_state == S_PROBE) ? r_probe_cnt + PC_W'(1) : '0;
            if (r_state != S_LOAD) begin
                r_total_bits <= '0;
            end else if (w_ser_shift) begin
                r_total_bits <= r_total_bits + TB_W'(1);
            end
            if (r_state == S_IDLE && start) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end else if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_val;
            end
        end
    end

    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_sb_ccff_loader.sv
// Scoreboard bench for sb_ccff_loader: a chain model, a handshake source and a monitor that pops expected results.
module tb_sb_ccff_loader;

    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 64;

    typedef struct {
        bit          isErr;
        logic [1:0]  code;
        int          latency;
        logic [63:0] chain;
        int          gap;
        int          lastRun;
    } expT;

    logic              prog_clk  = 1'b0;
    logic              pReset    = 1'b1;
    logic              start     = 1'b0;
    logic [WORD_W-1:0] cfg_data  = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              shift_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;

    logic [63:0] chainReg = '0;
    int          chainLen = 64;
    bit          broken   = 1'b0;

    logic [31:0] srcWords [3];
    int          srcGap [3];
    int          srcCount  = 0;
    bit          srcActive = 1'b0;
    int          srcIdx    = 0;
    int          srcWait   = 0;
    bit          hsSeen    = 1'b0;

    expT  expQ [$];
    expT  curExp;
    bit   runEnded    = 1'b0;
    int   cycleCnt    = 0;
    int   startCycle  = 0;
    int   acceptCnt   = 0;
    int   acceptAt [4];
    bit   readySeen   = 1'b0;
    int   runLen      = 0;
    int   lastRun     = 0;
    logic errPrev     = 1'b0;
    bit   stickyErr   = 1'b0;
    logic [1:0] stickyCode = 2'd0;

    sb_ccff_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 prog_clk = ~prog_clk;

    // Physical chain: index 0 is next to the head, index chainLen-1 drives the tail.
    always @(posedge prog_clk) begin
        if (shift_en) chainReg <= {chainReg[62:0], ccff_head};
    end
    assign ccff_tail = broken ? 1'b0 : chainReg[chainLen-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Word source: holds each word until accepted, then waits srcGap cycles before offering the next.
    always @(negedge prog_clk) hsSeen = cfg_valid && cfg_ready;

    always @(posedge prog_clk) begin
        #1;
        if (!srcActive) begin
            cfg_valid = 1'b0;
            srcIdx    = 0;
            srcWait   = 0;
        end else begin
            if (hsSeen) begin
                srcIdx++;
                srcWait = (srcIdx < srcCount) ? srcGap[srcIdx] : 0;
            end
            if (srcWait > 0) begin
                cfg_valid = 1'b0;
                srcWait--;
            end else if (srcIdx < srcCount) begin
                cfg_valid = 1'b1;
                cfg_data  = srcWords[srcIdx];
            end else begin
                cfg_valid = 1'b0;
            end
        end
    end

    function automatic logic [63:0] expChain(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] stream;
        logic [63:0] r;
        stream = {w1, w0};
        for (int k = 0; k < 64; k++) r[63-k] = stream[k];
        return r;
    endfunction

    // Monitor: tracks handshakes and shift runs, and scores each done pulse or new error.
    always @(negedge prog_clk) begin
        cycleCnt++;
        if (start && !busy) begin
            startCycle = cycleCnt;
            acceptCnt  = 0;
            readySeen  = 1'b0;
            runLen     = 0;
            lastRun    = 0;
        end
        if (cfg_valid && cfg_ready) begin
            if (acceptCnt < 4) acceptAt[acceptCnt] = cycleCnt;
            acceptCnt++;
        end
        if (cfg_ready) readySeen = 1'b1;
        if (shift_en) begin
            runLen++;
        end else begin
            if (runLen > 0) lastRun = runLen;
            runLen = 0;
        end
        if (done || (err && !errPrev)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedEnd: got done=%0b err=%0b expected no completion", done, err);
            end else begin
                curExp = expQ.pop_front();
                checkOutput("endKind", 64'(!done), 64'(curExp.isErr));
                checkOutput("latency", 64'(cycleCnt - startCycle), 64'(curExp.latency));
                if (!curExp.isErr) begin
                    checkOutput("chainContents", chainReg, curExp.chain);
                    checkOutput("wordsAccepted", 64'(acceptCnt), 64'd2);
                    checkOutput("acceptGap", 64'((acceptCnt >= 2) ? acceptAt[1] - acceptAt[0] : -1), 64'(curExp.gap));
                    checkOutput("finalShiftRun", 64'(lastRun), 64'(curExp.lastRun));
                    checkOutput("errOnDone", {62'd0, err_code}, 64'(err));
                    checkOutput("busyOnDone", 64'(busy), 64'd1);
                end else begin
                    checkOutput("errCode", 64'(err_code), 64'(curExp.code));
                    checkOutput("readyNeverSeen", 64'(readySeen), 64'd0);
                    checkOutput("shiftEnInErr", 64'(shift_en), 64'd0);
                end
                runEnded = 1'b1;
            end
        end
        errPrev = err;
    end

    // mode 0: 64-flop chain, 1: 60-flop chain, 2: tail stuck at 0.
    task automatic applyStimulus(input int mode, input logic [31:0] w0, input logic [31:0] w1,
                                 input int gap, input bit extra, input bit busyStart, input int abortAt);
        expT e;
        int  stall;
        bit  aborted;
        aborted = 1'b0;
        @(negedge prog_clk);
        chainLen    = (mode == 1) ? 60 : 64;
        broken      = (mode == 2);
        srcWords[0] = w0;
        srcWords[1] = w1;
        srcWords[2] = $urandom;
        srcGap[0]   = 0;
        srcGap[1]   = gap;
        srcGap[2]   = $urandom_range(0, 3);
        srcCount    = (mode == 0) ? (extra ? 3 : 2) : 1;
        srcActive   = 1'b1;
        runEnded    = 1'b0;
        stall       = (gap > WORD_W - 1) ? gap - (WORD_W - 1) : 0;
        e.isErr     = (mode != 0);
        e.code      = (mode == 1) ? 2'd2 : (mode == 2) ? 2'd1 : 2'd0;
        e.latency   = (mode == 0) ? 3 * CHAIN_LEN + 3 + stall :
                      (mode == 1) ? CHAIN_LEN + 60 + 2 : 3 * CHAIN_LEN + 2;
        e.chain     = expChain(w0, w1);
        e.gap       = WORD_W + stall;
        e.lastRun   = (stall > 0) ? WORD_W : CHAIN_LEN;
        if (abortAt == 0) expQ.push_back(e);
        if (stickyErr) begin
            checkOutput("errSticky", 64'(err), 64'd1);
            checkOutput("codeSticky", 64'(err_code), 64'(stickyCode));
        end
        @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
        checkOutput("errClearedOnStart", {61'd0, err, err_code}, 64'd0);
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        for (int c = 0; c < 900 && !runEnded; c++) begin
            @(posedge prog_clk);
            #1 start = busyStart && (c == 20);
            if (abortAt > 0 && c == abortAt) begin
                #2 pReset = 1'b1;
                #1 checkOutput("asyncResetOutputs",
                               {56'd0, busy, done, err, err_code, shift_en, cfg_ready, ccff_head}, 64'd0);
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (aborted) begin
            repeat (2) @(negedge prog_clk);
            pReset = 1'b0;
            @(negedge prog_clk);
            checkOutput("idleAfterAbort", {62'd0, busy, done}, 64'd0);
            stickyErr = 1'b0;
        end else if (!runEnded) begin
            checks++;
            errors++;
            $display("[TB] FAIL runTimeout: got no done/err within bound expected completion (mode %0d)", mode);
            expQ.delete();
        end else begin
            checkOutput("doneSinglePulse", {62'd0, busy, done}, 64'd0);
            stickyErr  = e.isErr;
            stickyCode = e.code;
        end
        @(negedge prog_clk);
        srcActive = 1'b0;
        repeat (2) @(negedge prog_clk);
    endtask

    initial begin
        repeat (3) @(negedge prog_clk);
        checkOutput("outputsInReset", {56'd0, busy, done, err, err_code, shift_en, cfg_ready, ccff_head}, 64'd0);
        pReset = 1'b0;
        @(negedge prog_clk);
        checkOutput("outputsAfterReset", {56'd0, busy, done, err, err_code, shift_en, cfg_ready, ccff_head}, 64'd0);

        applyStimulus(0, 32'hA5A5_0001, 32'h0000_FFFF, 0, 1'b0, 1'b1, 0);
        applyStimulus(0, 32'hA5A5_0001, 32'h0000_FFFF, 36, 1'b1, 1'b0, 0);
        applyStimulus(1, 32'hA5A5_0001, 32'h0000_FFFF, 0, 1'b0, 1'b0, 0);
        applyStimulus(2, 32'hA5A5_0001, 32'h0000_FFFF, 0, 1'b0, 1'b0, 0);
        applyStimulus(0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b1, 140);
        applyStimulus(0, 32'hA5A5_0001, 32'h0000_FFFF, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, $urandom, $urandom, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
